// File: rtl/quad_pkg.sv
// Shared types and Gray-code lookups for the quadrature decoder.
package quad_pkg;

    typedef logic [1:0] phase_t;

    typedef enum logic {
        INIT,
        TRACK
    } state_t;

    // Indexed by the previous {a,b}; up order is 00->01->11->10->00.
    localparam phase_t GRAY_NEXT [4] = '{2'b01, 2'b11, 2'b00, 2'b10};
    localparam phase_t GRAY_PREV [4] = '{2'b10, 2'b00, 2'b11, 2'b01};

endpackage

// File: rtl/sync_filt.sv
// Two-flop synchroniser for the {a,b} pair followed by a stability filter.
// f_ab is taken from s_ab in the cycle the candidate completes FILT stable samples.
module sync_filt
    import quad_pkg::*;
#(
    parameter int FILT = 2
) (
    input  logic   clk,
    input  logic   clr_n,
    input  logic   a,
    input  logic   b,
    output phase_t f_ab,
    output logic   valid
);

    phase_t     sync1_q;
    phase_t     s_ab;
    logic [1:0] prm_q;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            sync1_q <= '0;
            s_ab    <= '0;
            prm_q   <= '0;
        end else begin
            sync1_q <= {a, b};
            s_ab    <= sync1_q;
            prm_q   <= {prm_q[0], 1'b1};
        end
    end

    if (FILT == 0) begin : g_bypass
        assign f_ab  = s_ab;
        assign valid = prm_q[1];
    end else begin : g_filt
        localparam int CW = $clog2(FILT + 1);
        localparam logic [CW-1:0] LAST = CW'(FILT - 1);
        localparam logic [CW-1:0] FULL = CW'(FILT);

        logic [CW-1:0] cnt_q;
        phase_t        cand_q;
        phase_t        f_q;
        logic          valid_q;
        logic          accept;

        // s_ab is only meaningful once the synchroniser has been refilled after reset
        assign accept = prm_q[1] && (s_ab == cand_q) && (cnt_q == LAST);

        always_ff @(posedge clk or negedge clr_n) begin
            if (!clr_n) begin
                cnt_q   <= '0;
                cand_q  <= '0;
                f_q     <= '0;
                valid_q <= 1'b0;
            end else begin
                if (prm_q[1]) begin
                    if (s_ab != cand_q) begin
                        cand_q <= s_ab;
                        cnt_q  <= '0;
                    end else if (cnt_q != FULL) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                if (accept) begin
                    f_q     <= s_ab;
                    valid_q <= 1'b1;
                end
            end
        end

        assign f_ab  = accept ? s_ab : f_q;
        assign valid = valid_q | accept;
    end

endmodule

// File: rtl/quad_decoder.sv
// Quadrature decoder: filtered A/B -> up/down/illegal events, loadable position count.
// state | meaning
// INIT  | wait for first valid filtered sample, capture it as reference
// TRACK | compare each filtered sample with the previous one and count
module quad_decoder
    import quad_pkg::*;
#(
    parameter int n    = 8,
    parameter int FILT = 2,
    parameter int ECW  = 4
) (
    input  logic           clk,
    input  logic           clr_n,
    input  logic           a,
    input  logic           b,
    input  logic           ld,
    input  logic [n-1:0]   D,
    output logic [n-1:0]   count,
    output logic           dir,
    output logic           step,
    output logic           rco,
    output logic           err,
    output logic [ECW-1:0] err_cnt
);

    phase_t f_ab;
    logic   valid;

    state_t         state_q, state_d;
    phase_t         prev_q, prev_d;
    logic [n-1:0]   count_d;
    logic           dir_d, step_d, rco_d, err_d;
    logic [ECW-1:0] err_cnt_d;

    sync_filt #(.FILT(FILT)) u_sync_filt (
        .clk   (clk),
        .clr_n (clr_n),
        .a     (a),
        .b     (b),
        .f_ab  (f_ab),
        .valid (valid)
    );

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q <= INIT;
            prev_q  <= '0;
            count   <= '0;
            dir     <= 1'b1;
            step    <= 1'b0;
            rco     <= 1'b0;
            err     <= 1'b0;
            err_cnt <= '0;
        end else begin
            state_q <= state_d;
            prev_q  <= prev_d;
            count   <= count_d;
            dir     <= dir_d;
            step    <= step_d;
            rco     <= rco_d;
            err     <= err_d;
            err_cnt <= err_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        prev_d    = prev_q;
        count_d   = count;
        dir_d     = dir;
        step_d    = 1'b0;
        rco_d     = 1'b0;
        err_d     = 1'b0;
        err_cnt_d = err_cnt;

        case (state_q)
            INIT: begin
                if (valid) begin
                    prev_d  = f_ab;
                    state_d = TRACK;
                end
            end
            TRACK: begin
                prev_d = f_ab;
                if (f_ab == GRAY_NEXT[prev_q]) begin
                    step_d  = 1'b1;
                    dir_d   = 1'b1;
                    count_d = count + 1'b1;
                    rco_d   = (count == '1);
                end else if (f_ab == GRAY_PREV[prev_q]) begin
                    step_d  = 1'b1;
                    dir_d   = 1'b0;
                    count_d = count - 1'b1;
                    rco_d   = (count == '0);
                end else if (f_ab != prev_q) begin
                    err_d = 1'b1;
                    if (err_cnt != '1) begin
                        err_cnt_d = err_cnt + 1'b1;
                    end
                end
            end
            default: state_d = INIT;
        endcase

        // Load wins over the decoded step; step/dir still report the event.
        if (ld) begin
            count_d = D;
            rco_d   = 1'b0;
        end
    end

endmodule

// File: tb/tb_quad_decoder.sv
// Directed bench for quad_decoder (n=8, FILT=2, ECW=4) with immediate-assertion checks.
module tb_quad_decoder;

    localparam int N    = 8;
    localparam int FILT = 2;
    localparam int ECW  = 4;

    logic           clk = 1'b0;
    logic           clr_n;
    logic           a, b, ld;
    logic [N-1:0]   d;
    logic [N-1:0]   count;
    logic           dir, step, rco, err;
    logic [ECW-1:0] err_cnt;

    int checks = 0;
    int errors = 0;
    int nsteps;
    int nerrs;
    logic [1:0] v;

    always #5 clk = ~clk;

    quad_decoder #(.n(N), .FILT(FILT), .ECW(ECW)) dut (
        .clk     (clk),
        .clr_n   (clr_n),
        .a       (a),
        .b       (b),
        .ld      (ld),
        .D       (d),
        .count   (count),
        .dir     (dir),
        .step    (step),
        .rco     (rco),
        .err     (err),
        .err_cnt (err_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int k);
        repeat (k) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drive a new {a,b}; the event must appear exactly 5 cycles later and last one cycle.
    task automatic step_to(input string tag, input logic [1:0] val, input logic exp_step,
                           input logic exp_dir, input logic [7:0] exp_cnt,
                           input logic exp_rco, input logic exp_err);
        {a, b} = val;
        tick(4);
        chk({tag, "_early"}, {30'd0, step, err}, 32'd0);
        tick(1);
        chk({tag, "_step"}, {31'd0, step}, {31'd0, exp_step});
        chk({tag, "_dir"}, {31'd0, dir}, {31'd0, exp_dir});
        chk({tag, "_count"}, {24'd0, count}, {24'd0, exp_cnt});
        chk({tag, "_rco"}, {31'd0, rco}, {31'd0, exp_rco});
        chk({tag, "_err"}, {31'd0, err}, {31'd0, exp_err});
        tick(1);
        chk({tag, "_pulse"}, {29'd0, step, rco, err}, 32'd0);
        tick(2);
    endtask

    task automatic watch(input int k);
        nsteps = 0;
        nerrs  = 0;
        repeat (k) begin
            tick(1);
            if (step) nsteps++;
            if (err)  nerrs++;
        end
    endtask

    initial begin
        clr_n = 1'b0;
        a = 1'b0; b = 1'b0; ld = 1'b0; d = '0;
        tick(3);
        chk("rst_count", {24'd0, count}, 32'h00);
        chk("rst_dir", {31'd0, dir}, 32'd1);
        chk("rst_pulses", {29'd0, step, rco, err}, 32'd0);
        chk("rst_err_cnt", {28'd0, err_cnt}, 32'd0);
        clr_n = 1'b1;
        tick(6);

        step_to("up1", 2'b01, 1'b1, 1'b1, 8'h01, 1'b0, 1'b0);
        step_to("up2", 2'b11, 1'b1, 1'b1, 8'h02, 1'b0, 1'b0);
        step_to("up3", 2'b10, 1'b1, 1'b1, 8'h03, 1'b0, 1'b0);
        step_to("up4", 2'b00, 1'b1, 1'b1, 8'h04, 1'b0, 1'b0);
        chk("up_err_cnt", {28'd0, err_cnt}, 32'd0);

        ld = 1'b1; d = 8'h02;
        tick(1);
        ld = 1'b0;
        chk("ld02", {24'd0, count}, 32'h02);
        step_to("dn1", 2'b10, 1'b1, 1'b0, 8'h01, 1'b0, 1'b0);
        step_to("dn2", 2'b11, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        step_to("dn3", 2'b01, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0);

        ld = 1'b1; d = 8'hFE;
        tick(1);
        ld = 1'b0;
        chk("ldFE", {24'd0, count}, 32'hFE);
        step_to("wr1", 2'b11, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0);
        step_to("wr2", 2'b10, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0);
        step_to("up5", 2'b00, 1'b1, 1'b1, 8'h01, 1'b0, 1'b0);

        step_to("ill1", 2'b11, 1'b0, 1'b1, 8'h01, 1'b0, 1'b1);
        chk("ill1_err_cnt", {28'd0, err_cnt}, 32'd1);
        v = 2'b11;
        for (int i = 0; i < 13; i++) begin
            v = ~v;
            {a, b} = v;
            tick(8);
        end
        chk("ill14_err_cnt", {28'd0, err_cnt}, 32'hE);
        for (int i = 0; i < 6; i++) begin
            v = ~v;
            {a, b} = v;
            tick(8);
        end
        chk("ill20_err_cnt", {28'd0, err_cnt}, 32'hF);
        chk("ill_count", {24'd0, count}, 32'h01);
        chk("ill_dir", {31'd0, dir}, 32'd1);

        {a, b} = 2'b01;
        tick(1);
        {a, b} = 2'b00;
        watch(10);
        chk("glitch1_steps", nsteps, 0);
        chk("glitch1_count", {24'd0, count}, 32'h01);

        {a, b} = 2'b01;
        tick(2);
        {a, b} = 2'b00;
        watch(10);
        chk("glitch2_steps", nsteps, 0);
        chk("glitch2_count", {24'd0, count}, 32'h01);

        {a, b} = 2'b01;
        tick(3);
        {a, b} = 2'b00;
        watch(12);
        chk("hold3_steps", nsteps, 2);
        chk("hold3_count", {24'd0, count}, 32'h01);
        chk("hold3_dir", {31'd0, dir}, 32'd0);

        ld = 1'b1; d = 8'hFF;
        tick(1);
        ld = 1'b0;
        chk("ldFF", {24'd0, count}, 32'hFF);
        {a, b} = 2'b01;
        tick(4);
        ld = 1'b1; d = 8'h55;
        tick(1);
        chk("ldstep_count", {24'd0, count}, 32'h55);
        chk("ldstep_step", {31'd0, step}, 32'd1);
        chk("ldstep_dir", {31'd0, dir}, 32'd1);
        chk("ldstep_rco", {31'd0, rco}, 32'd0);
        d = 8'h12;
        tick(1);
        chk("ldhold1", {24'd0, count}, 32'h12);
        d = 8'h34;
        tick(1);
        chk("ldhold2", {24'd0, count}, 32'h34);
        ld = 1'b0;
        tick(3);

        {a, b} = 2'b11;
        tick(2);
        clr_n = 1'b0;
        #1;
        chk("mid_rst_count", {24'd0, count}, 32'h00);
        chk("mid_rst_dir", {31'd0, dir}, 32'd1);
        chk("mid_rst_pulses", {29'd0, step, rco, err}, 32'd0);
        chk("mid_rst_err_cnt", {28'd0, err_cnt}, 32'd0);
        tick(2);
        clr_n = 1'b1;
        watch(12);
        chk("release_steps", nsteps, 0);
        chk("release_errs", nerrs, 0);
        chk("release_count", {24'd0, count}, 32'h00);
        step_to("post", 2'b10, 1'b1, 1'b1, 8'h01, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/quad_decoder.md
Name: quad_decoder

Overview:
- Quadrature decoder driving the up/down count path from a two-phase encoder (A/B).
- Synchronises and filters asynchronous A/B inputs and classifies each Gray-code transition as an up step, a down step or an illegal jump.
- Maintains a loadable n-bit position count with direction-dependent ripple-carry/borrow.
- Acts as the producer side of the lab counter datapath, feeding position, direction and step events to display and control logic.

Parameters:
- n, 8, width of position count and load data.
- FILT, 2, consecutive stable cycles required on synchronised A/B before a new value is accepted. 0 bypasses the filter.
- ECW, 4, width of the saturating illegal-transition counter.

Ports:
- clk  in  1  system clock; all flops are rising-edge.
- clr_n  in  1  asynchronous active-low reset.
- a  in  1  encoder phase A, asynchronous to clk.
- b  in  1  encoder phase B, asynchronous to clk.
- ld  in  1  synchronous load of position from D.
- D  in  n  load value.
- count  out  n  current position.
- dir  out  1  direction of last valid step: 1 = up, 0 = down.
- step  out  1  one-cycle pulse per valid step.
- rco  out  1  one-cycle pulse on wrap: up from all-ones to 0, or down from 0 to all-ones.
- err  out  1  one-cycle pulse on an illegal transition (both phases changed).
- err_cnt  out  ECW  saturating count of illegal transitions.

Behaviour:
- Reset (clr_n low, asynchronous):
  - count=0, dir=1, step=0, rco=0, err=0, err_cnt=0.
  - Synchroniser flops, filter counter and previous-AB register cleared.
  - FSM goes to INIT.
- Synchroniser: two flops per phase. The filter stage only ever sees the synchronised pair s_ab={a,b}.
- Filter:
  - Compares s_ab against the candidate value each cycle.
  - Any change reloads the candidate and clears the stable counter.
  - f_ab updates to the candidate once it has been stable for FILT cycles.
  - FILT=0: f_ab = s_ab.
- FSM:
  - INIT: on the first cycle after reset release with filter output valid, capture f_ab into prev_ab, go to TRACK. No step, err or count change.
  - TRACK: every cycle compare f_ab to prev_ab, then prev_ab <= f_ab.
    - Equal: no event.
    - Up sequence 00->01->11->10->00: step=1, dir=1, count+1.
    - Reverse sequence: step=1, dir=0, count-1.
    - Both bits differ (00<->11, 01<->10): err=1, err_cnt+1 saturating at all-ones; count and dir unchanged.
- Latency: an edge on a or b produces step/err exactly 2 + FILT + 1 clk cycles later, provided the edge is held stable.
- Arithmetic: count is modulo 2^n.
  - rco pulses in the same cycle as the wrapping step.
  - rco is never asserted for load or error cycles.
- Load: ld has priority over a step in the same cycle.
  - count <= D.
  - step and dir still reflect the decoded event.
  - rco = 0.
  - err handling is unaffected.
- All outputs are registered; pulses are exactly one cycle wide.
- Reset mid-operation: asynchronous clear as above. After release the FSM re-enters INIT, so the encoder position present at release is not counted.
- ld held high: count follows D every cycle.

Decomposition:
- Shared package `quad_pkg`:
  - 2-bit phase typedef.
  - FSM state enum {INIT, TRACK}.
  - Gray-sequence next/prev lookup constants.
- One natural sub-module: `sync_filt`, one instance per phase pair. It contains the 2-flop synchroniser plus the FILT stability counter and outputs f_ab and valid.

Test Plan (n=8, FILT=2, ECW=4):
- Reset, hold a=b=0, release clr_n, then drive AB 00->01->11->10->00 with 8 cycles per state -> 4 step pulses, dir=1, count=4, err=0. The first step occurs 5 cycles after the first edge.
- After ld=1 with D=8'h02, drive the reverse sequence for 3 steps -> count=8'hFF after the 3rd step, rco pulses once on the 0->FF step, dir=0.
- After ld with D=8'hFE, drive 2 up steps -> count=8'h00, rco pulses on the FF->00 step only.
- Jump AB 00->11 in one sample -> err one-cycle pulse, err_cnt=1, count unchanged. Repeat 20 illegal jumps -> err_cnt saturates at 4'hF.
- Apply a 1-cycle glitch on a (00->01->00 at clk rate) -> no step, count unchanged. A 2-cycle glitch is also rejected; a 3-cycle hold is accepted.
- ld=1 with D=8'h55 in the same cycle a valid up step is decoded -> count=8'h55, step=1, dir=1, rco=0. Then assert clr_n=0 mid-sequence -> all outputs 0 immediately (dir=1), and no step on release.
